// File: rtl/nn_pkg.sv
// Shared types, widths and the reference quantizer for the neural-node blocks.
// Both the serial layer sequencer and the parallel per-neuron nodes import this.
package nn_pkg;

  localparam int ACT_W          = 8;
  localparam int PROD_W         = 16;
  localparam int BIAS_W         = 16;
  localparam int ACC_W_DEF      = 23;
  localparam int FRAC_SHIFT_DEF = 6;
  localparam int AW_A_DEF       = 5;
  localparam int AW_W_DEF       = 9;
  localparam int AW_B_DEF       = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_QUANT = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // ReLU, clip to 127 and round half-up at the default accumulator geometry.
  function automatic logic [ACT_W-1:0] quantize(input logic [ACC_W_DEF-1:0] acc);
    logic [ACT_W:0] sum;
    sum = {1'b0, acc[FRAC_SHIFT_DEF+7:FRAC_SHIFT_DEF]} + {8'd0, acc[FRAC_SHIFT_DEF-1]};
    if (acc[ACC_W_DEF-1]) begin
      quantize = 8'd0;
    end else if (|acc[ACC_W_DEF-2:FRAC_SHIFT_DEF+7]) begin
      quantize = 8'd127;
    end else if (sum > 9'd127) begin
      quantize = 8'd127;
    end else begin
      quantize = sum[ACT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/neuron_layer_sequencer_if.sv
// Memory read ports and quantized output stream of the layer sequencer.
// master = sequencer side, slave = memories plus downstream consumer.
interface neuron_layer_sequencer_if
  import nn_pkg::*;
#(
  parameter int AW_A = AW_A_DEF,
  parameter int AW_W = AW_W_DEF,
  parameter int AW_B = AW_B_DEF
) ();

  logic        [AW_A-1:0]   act_addr;
  logic signed [ACT_W-1:0]  act_data;
  logic        [AW_W-1:0]   w_addr;
  logic signed [ACT_W-1:0]  w_data;
  logic        [AW_B-1:0]   b_addr;
  logic signed [BIAS_W-1:0] b_data;
  logic                     out_valid;
  logic                     out_ready;
  logic        [AW_B-1:0]   out_idx;
  logic        [ACT_W-1:0]  out_data;

  modport master (
    output act_addr, w_addr, b_addr, out_valid, out_idx, out_data,
    input  act_data, w_data, b_data, out_ready
  );

  modport slave (
    input  act_addr, w_addr, b_addr, out_valid, out_idx, out_data,
    output act_data, w_data, b_data, out_ready
  );

endinterface

// File: rtl/nn_quant.sv
// Combinational ReLU / saturate / round from a signed accumulator to 0..127.
// Shared with the parallel node blocks, hence the free geometry parameters.
module nn_quant
  import nn_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [ACT_W-1:0] q_o
);

  logic [ACT_W:0] sum;

  // Rounding carry can only reach 128, which clips back to 127.
  always_comb begin
    sum = {1'b0, acc_i[FRAC_SHIFT+7:FRAC_SHIFT]} + {8'd0, acc_i[FRAC_SHIFT-1]};
    if (acc_i[ACC_W-1]) begin
      q_o = 8'd0;
    end else if (|acc_i[ACC_W-2:FRAC_SHIFT+7]) begin
      q_o = 8'd127;
    end else if (sum > 9'd127) begin
      q_o = 8'd127;
    end else begin
      q_o = sum[ACT_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Serial fully-connected layer: one 8x8 MAC walks N_OUT neurons of N_IN inputs,
// then streams each quantized result over a valid/ready port.
module neuron_layer_sequencer
  import nn_pkg::*;
#(
  parameter int N_IN       = 30,
  parameter int N_OUT      = 16,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int AW_A       = AW_A_DEF,
  parameter int AW_W       = AW_W_DEF,
  parameter int AW_B       = AW_B_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  neuron_layer_sequencer_if.master bus
);

  state_e                   state_q, state_d;
  logic        [AW_A-1:0]   k_q, k_d;
  logic        [AW_B-1:0]   neuron_q, neuron_d;
  logic                     fetch_v_q, fetch_v_d;
  logic                     first_q, first_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     out_valid_q, out_valid_d;
  logic        [AW_B-1:0]   out_idx_q, out_idx_d;
  logic        [ACT_W-1:0]  out_data_q, out_data_d;
  logic        [AW_A-1:0]   act_addr_q, act_addr_d;
  logic        [AW_W-1:0]   w_addr_q, w_addr_d;
  logic        [AW_B-1:0]   b_addr_q, b_addr_d;

  logic signed [PROD_W-1:0] prod;
  logic        [ACT_W-1:0]  quant;
  logic                     last_k, last_n, accept;

  assign last_k = (k_q == AW_A'(N_IN - 1));
  assign last_n = (neuron_q == AW_B'(N_OUT - 1));
  assign accept = out_valid_q & bus.out_ready;
  assign prod   = $signed(PROD_W'(bus.act_data)) * $signed(PROD_W'(bus.w_data));

  nn_quant #(.ACC_W(ACC_W), .FRAC_SHIFT(FRAC_SHIFT)) u_quant (
    .acc_i (acc_q),
    .q_o   (quant)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH; else state_d = S_IDLE;
      S_FETCH: if (last_k) state_d = S_DRAIN; else state_d = S_FETCH;
      S_DRAIN: state_d = S_QUANT;
      S_QUANT: state_d = S_OUT;
      S_OUT: begin
        if (accept) begin
          if (last_n) state_d = S_DONE; else state_d = S_FETCH;
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; addresses lead the read data by one cycle.
  always_comb begin
    neuron_d = neuron_q;
    case (state_q)
      S_IDLE:  neuron_d = '0;
      S_OUT:   if (accept && !last_n) neuron_d = neuron_q + AW_B'(1); else neuron_d = neuron_q;
      default: neuron_d = neuron_q;
    endcase

    if (state_d == S_FETCH && state_q == S_FETCH) begin
      k_d = k_q + AW_A'(1);
    end else begin
      k_d = '0;
    end

    if (state_d == S_FETCH) begin
      act_addr_d = k_d;
      w_addr_d   = AW_W'(neuron_d) * AW_W'(N_IN) + AW_W'(k_d);
      b_addr_d   = neuron_d;
    end else begin
      act_addr_d = '0;
      w_addr_d   = '0;
      b_addr_d   = '0;
    end

    fetch_v_d = (state_q == S_FETCH);
    first_d   = (state_q == S_FETCH) && (k_q == '0);

    // Bias is folded in with the first product of each neuron.
    if (fetch_v_q) begin
      if (first_q) acc_d = ACC_W'(bus.b_data) + ACC_W'(prod);
      else         acc_d = acc_q + ACC_W'(prod);
    end else begin
      acc_d = acc_q;
    end

    if (state_q == S_QUANT) begin
      out_valid_d = 1'b1;
      out_data_d  = quant;
      out_idx_d   = neuron_q;
    end else if (accept) begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q         <= '0;
      neuron_q    <= '0;
      fetch_v_q   <= 1'b0;
      first_q     <= 1'b0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      act_addr_q  <= '0;
      w_addr_q    <= '0;
      b_addr_q    <= '0;
    end else begin
      k_q         <= k_d;
      neuron_q    <= neuron_d;
      fetch_v_q   <= fetch_v_d;
      first_q     <= first_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      act_addr_q  <= act_addr_d;
      w_addr_q    <= w_addr_d;
      b_addr_q    <= b_addr_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_data  = out_data_q;
  assign bus.act_addr  = act_addr_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.b_addr    = b_addr_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Bench for neuron_layer_sequencer: memories modelled in arrays, expected layer
// outputs computed with plain integer arithmetic and checked every valid cycle.
module tb_neuron_layer_sequencer;
  import nn_pkg::*;

  localparam int N_IN  = 30;
  localparam int N_OUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  neuron_layer_sequencer_if bus ();

  neuron_layer_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic signed [7:0]  act_mem [N_IN];
  logic signed [7:0]  w_mem   [N_IN*N_OUT];
  logic signed [15:0] b_mem   [N_OUT];

  int exp_q [N_OUT];
  int got   [N_OUT];
  int tests = 0;
  int fails = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;
  bit prev_hs = 1'b0;
  int prev_idx = 0;

  // Synchronous-read memories, one cycle of latency.
  always @(posedge clk) begin
    bus.act_data <= act_mem[bus.act_addr];
    bus.w_data   <= w_mem[bus.w_addr];
    bus.b_data   <= b_mem[bus.b_addr];
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Round-half-up of acc/64, with negatives to 0 and anything above 127 clipped.
  function automatic int model_quant(input longint v);
    longint r;
    if (v < 0) return 0;
    r = (v + 32) / 64;
    if (r > 127) return 127;
    return int'(r);
  endfunction

  function automatic int model_neuron(input int n);
    longint acc;
    acc = longint'(b_mem[n]);
    for (int k = 0; k < N_IN; k++)
      acc += longint'(act_mem[k]) * longint'(w_mem[n*N_IN + k]);
    acc = acc % (64'sd1 <<< 23);
    if (acc >= (64'sd1 <<< 22)) acc -= (64'sd1 <<< 23);
    if (acc < -(64'sd1 <<< 22)) acc += (64'sd1 <<< 23);
    return model_quant(acc);
  endfunction

  // Per-cycle compare against the model while the DUT is out of reset.
  always @(negedge clk) begin
    if (reset && chk_en) begin
      if (prev_hs && prev_idx < N_OUT-1) begin
        check("next_neuron_w_addr", int'(bus.w_addr), (prev_idx+1)*N_IN);
        check("next_neuron_b_addr", int'(bus.b_addr), prev_idx+1);
      end
      if (bus.out_valid) begin
        if (out_cnt < N_OUT) begin
          check("out_idx", int'(bus.out_idx), out_cnt);
          check("out_data", int'(bus.out_data), exp_q[out_cnt]);
          check("addr_quiet", int'(bus.act_addr) + int'(bus.w_addr) + int'(bus.b_addr), 0);
          if (bus.out_ready) got[out_cnt] = int'(bus.out_data);
        end else begin
          check("extra_output", out_cnt, N_OUT-1);
        end
        if (bus.out_ready) out_cnt++;
      end else if (busy) begin
        check("w_addr_map", int'(bus.w_addr), int'(bus.b_addr)*N_IN + int'(bus.act_addr));
      end
      prev_hs  = bus.out_valid && bus.out_ready;
      prev_idx = int'(bus.out_idx);
      if (done) done_cnt++;
    end
  end

  task automatic fill(input int mode);
    for (int k = 0; k < N_IN; k++) begin
      case (mode)
        0, 4:    act_mem[k] = 8'sd0;
        1:       act_mem[k] = 8'sd64;
        2:       act_mem[k] = 8'sd10;
        3:       act_mem[k] = 8'sd127;
        default: act_mem[k] = 8'($urandom_range(0, 60) - 30);
      endcase
    end
    for (int i = 0; i < N_IN*N_OUT; i++) begin
      case (mode)
        1:       w_mem[i] = 8'sd2;
        2:       w_mem[i] = -8'sd1;
        3:       w_mem[i] = 8'sd127;
        default: w_mem[i] = 8'($urandom_range(0, 255));
      endcase
    end
    for (int n = 0; n < N_OUT; n++) begin
      case (mode)
        0:       b_mem[n] = 16'sd512;
        1, 2, 3: b_mem[n] = 16'sd0;
        default: b_mem[n] = 16'($urandom_range(0, 16383) - 4096);
      endcase
    end
    if (mode == 4) begin
      b_mem[0] = 16'sd96;
      b_mem[1] = 16'sd95;
      b_mem[2] = 16'sd8160;
      b_mem[3] = 16'sd8192;
    end
  endtask

  task automatic run_layer(input int rmode, input int bp_idx, input bit poke, input bit chk_lat);
    int n;
    int first_v;
    int hold;
    for (int i = 0; i < N_OUT; i++) begin
      exp_q[i] = model_neuron(i);
      got[i]   = -1;
    end
    out_cnt  = 0;
    done_cnt = 0;
    prev_hs  = 1'b0;
    chk_en   = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    n = 0;
    first_v = -1;
    hold = 0;
    while (!done && n < 3000) begin
      if (rmode == 0) bus.out_ready = 1'b1;
      else bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && int'(bus.out_idx) == bp_idx && hold < 10) begin
        bus.out_ready = 1'b0;
        hold++;
      end
      start = (poke && busy && $urandom_range(0, 7) == 0);
      @(posedge clk); #1;
      n++;
      if (first_v < 0 && bus.out_valid) first_v = n;
    end
    if (n >= 3000) begin
      check("done_timeout", n, 0);
      reset = 1'b0;
      #3 reset = 1'b1;
      start = 1'b0;
      return;
    end
    if (chk_lat) check("first_valid_latency", first_v, N_IN+2);
    if (bp_idx >= 0) check("backpressure_cycles", hold, 10);
    check("busy_in_done", int'(busy), 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_done", int'(busy), 0);
    check("done_one_cycle", int'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    check("start_in_done_ignored", int'(busy), 0);
    check("done_pulses", done_cnt, 1);
    check("outputs_seen", out_cnt, N_OUT);
  endtask

  task automatic abort_at_neuron5();
    int n;
    for (int i = 0; i < N_OUT; i++) exp_q[i] = model_neuron(i);
    out_cnt  = 0;
    done_cnt = 0;
    prev_hs  = 1'b0;
    chk_en   = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(out_cnt == 5 && busy && int'(bus.b_addr) == 5 && int'(bus.act_addr) == 3) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reached_neuron5", int'(bus.b_addr), 5);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_out_data", int'(bus.out_data), 0);
    check("abort_out_idx", int'(bus.out_idx), 0);
    check("abort_addrs", int'(bus.act_addr) + int'(bus.w_addr) + int'(bus.b_addr), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_stays_idle", int'(busy), 0);
    check("abort_no_done", done_cnt, 0);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    fill(0);
    #12;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_data", int'(bus.out_data), 0);
    check("reset_out_idx", int'(bus.out_idx), 0);
    check("reset_addrs", int'(bus.act_addr) + int'(bus.w_addr) + int'(bus.b_addr), 0);
    @(negedge clk) reset = 1'b1;

    check("model_pin_round_up", model_quant(64'sd96), 2);
    check("model_pin_round_down", model_quant(64'sd95), 1);
    check("model_pin_carry_sat", model_quant(64'sd8160), 127);
    check("model_pin_negative", model_quant(-64'sd300), 0);

    fill(0);
    run_layer(0, -1, 1'b0, 1'b1);
    check("bias512_first", got[0], 8);
    check("bias512_last", got[N_OUT-1], 8);

    fill(1);
    run_layer(0, -1, 1'b0, 1'b0);
    check("acc3840_first", got[0], 60);
    check("acc3840_last", got[N_OUT-1], 60);

    fill(2);
    run_layer(0, -1, 1'b0, 1'b0);
    check("negative_relu", got[5], 0);

    fill(3);
    run_layer(0, -1, 1'b0, 1'b0);
    check("large_saturate", got[9], 127);

    fill(4);
    run_layer(0, -1, 1'b0, 1'b0);
    check("round_bias96", got[0], 2);
    check("round_bias95", got[1], 1);
    check("round_bias8160", got[2], 127);
    check("round_bias8192", got[3], 127);

    fill(5);
    run_layer(0, 3, 1'b0, 1'b1);

    fill(5);
    abort_at_neuron5();

    fill(5);
    run_layer(0, -1, 1'b1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      fill(5);
      run_layer(1, int'($urandom_range(0, N_OUT-1)), 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
